// File: rtl/sram_loader.sv
// sram_loader: packs a big-endian byte stream into 16-bit instruction words
// and writes them to asynchronous SRAM at consecutive addresses, stopping
// after the end word (bits [15:12] = 0000) or when the address space runs out.
module sram_loader #(
  // Cycles SRAM_WE is held low per write; legal range 1..8.
  parameter int unsigned WE_CYCLES = 2,
  parameter logic [17:0] BASE_ADDR = 18'h00000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_in_data,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic        o_sram_we,
  output logic        o_sram_ce,
  output logic        o_sram_oe,
  output logic        o_sram_lb,
  output logic        o_sram_ub,
  output logic [17:0] o_sram_a,
  output logic [15:0] o_sram_dq_out,
  output logic        o_sram_dq_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overflow,
  output logic [17:0] o_word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(WE_CYCLES - 1);
  localparam logic [17:0] LAST_ADDR = 18'h3FFFF;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_strobe_cnt;
  logic [CNT_W-1:0] w_next_strobe_cnt;
  logic [17:0]      r_sram_a;
  logic [17:0]      w_next_sram_a;
  logic [15:0]      r_sram_dq_out;
  logic [15:0]      w_next_sram_dq_out;
  logic [17:0]      r_word_count;
  logic [17:0]      w_next_word_count;
  logic             r_busy;
  logic             w_next_busy;
  logic             r_done;
  logic             w_next_done;
  logic             r_overflow;
  logic             w_next_overflow;
  logic             r_sram_we;
  logic             r_sram_ce;
  logic             r_sram_oe;
  logic             r_sram_lb;
  logic             r_sram_ub;
  logic             r_sram_dq_en;
  logic             w_in_ready;
  logic             w_bus_active;

  // Ready is a pure state decode so the upstream valid never loops back into it.
  assign w_in_ready = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);

  // The SRAM owns the bus for the whole SETUP..HOLD window of the coming cycle.
  assign w_bus_active = (w_next_state == S_SETUP) || (w_next_state == S_STROBE) ||
                        (w_next_state == S_HOLD);

  // Next-state and datapath decode for the load sequencer.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    w_next_state       = r_state;
    w_next_strobe_cnt  = r_strobe_cnt;
    w_next_sram_a      = r_sram_a;
    w_next_sram_dq_out = r_sram_dq_out;
    w_next_word_count  = r_word_count;
    w_next_busy        = r_busy;
    w_next_done        = r_done;
    w_next_overflow    = r_overflow;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_next_sram_a     = BASE_ADDR;
          w_next_word_count = '0;
          w_next_done       = 1'b0;
          w_next_overflow   = 1'b0;
          w_next_busy       = 1'b1;
          w_next_state      = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (i_in_valid && w_in_ready) begin
          w_next_sram_dq_out[15:8] = i_in_data;
          w_next_state             = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (i_in_valid && w_in_ready) begin
          w_next_sram_dq_out[7:0] = i_in_data;
          w_next_state            = S_SETUP;
        end
      end
      S_SETUP: begin
        w_next_strobe_cnt = '0;
        w_next_state      = S_STROBE;
      end
      S_STROBE: begin
        if (r_strobe_cnt == STROBE_LAST) begin
          w_next_state = S_HOLD;
        end else begin
          w_next_strobe_cnt = r_strobe_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        // Address wraps naturally from 3FFFF to 0 in 18 bits.
        w_next_word_count = r_word_count + 18'd1;
        w_next_sram_a     = r_sram_a + 18'd1;
        if (r_sram_dq_out[15:12] == 4'h0) begin
          w_next_busy  = 1'b0;
          w_next_done  = 1'b1;
          w_next_state = S_DONE;
        end else if (r_sram_a == LAST_ADDR) begin
          w_next_busy     = 1'b0;
          w_next_done     = 1'b1;
          w_next_overflow = 1'b1;
          w_next_state    = S_DONE;
        end else begin
          w_next_state = S_WAIT_HI;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered SRAM strobes; strobes decode the next state
  // so they line up exactly with the state they belong to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_strobe_cnt  <= '0;
      r_sram_a      <= BASE_ADDR;
      r_sram_dq_out <= '0;
      r_word_count  <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_sram_we     <= 1'b1;
      r_sram_ce     <= 1'b1;
      r_sram_oe     <= 1'b1;
      r_sram_lb     <= 1'b1;
      r_sram_ub     <= 1'b1;
      r_sram_dq_en  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state       <= w_next_state;
      r_strobe_cnt  <= w_next_strobe_cnt;
      r_sram_a      <= w_next_sram_a;
      r_sram_dq_out <= w_next_sram_dq_out;
      r_word_count  <= w_next_word_count;
      r_busy        <= w_next_busy;
      r_done        <= w_next_done;
      r_overflow    <= w_next_overflow;
      r_sram_we     <= (w_next_state != S_STROBE);
      r_sram_ce     <= !w_bus_active;
      r_sram_oe     <= 1'b1;
      r_sram_lb     <= !w_bus_active;
      r_sram_ub     <= !w_bus_active;
      r_sram_dq_en  <= w_bus_active;
    end
  end

  assign o_in_ready    = w_in_ready;
  assign o_sram_we     = r_sram_we;
  assign o_sram_ce     = r_sram_ce;
  assign o_sram_oe     = r_sram_oe;
  assign o_sram_lb     = r_sram_lb;
  assign o_sram_ub     = r_sram_ub;
  assign o_sram_a      = r_sram_a;
  assign o_sram_dq_out = r_sram_dq_out;
  assign o_sram_dq_en  = r_sram_dq_en;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_overflow    = r_overflow;
  assign o_word_count  = r_word_count;

endmodule

// File: doc/sram_loader.md
# sram_loader

Writes a Bythoven song program into the board SRAM before playback. Accepts a byte stream with a valid/ready handshake, typically from a UART receiver. Packs byte pairs into 16-bit instruction words and performs one SRAM write cycle per word at consecutive addresses. It is the write-side counterpart of the CPU instruction fetch, which reads the same words back from address 0 upward. Loading stops after the end instruction (bits [15:12] = 0000) is stored.

## Interface
- WE_CYCLES, 2: number of cycles SRAM_WE is held low per write; legal values are 1 to 8.
- BASE_ADDR, 18'h00000: first SRAM address written after START.
- CLK  in  1  50 MHz system clock; every register uses its rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- START  in  1  single-cycle pulse that begins a load; acted on only in IDLE or DONE.
- IN_DATA  in  8  stream byte.
- IN_VALID  in  1  IN_DATA is valid.
- IN_READY  out  1  loader will accept a byte this cycle.
- SRAM_WE  out  1  write enable, active-low.
- SRAM_CE  out  1  chip enable, active-low.
- SRAM_OE  out  1  output enable, active-low; held 1 at all times.
- SRAM_LB  out  1  lower byte enable, active-low.
- SRAM_UB  out  1  upper byte enable, active-low.
- SRAM_A  out  18  write address.
- SRAM_DQ_OUT  out  16  write data; the top level drives the tristate.
- SRAM_DQ_EN  out  1  when 1, the top level drives SRAM_DQ_OUT onto the data bus.
- BUSY  out  1  a load is in progress.
- DONE  out  1  load finished; sticky until the next START or reset.
- OVERFLOW  out  1  address space was exhausted before the end word; sticky.
- WORD_COUNT  out  18  number of words written in the current load.

## Operation
- States: IDLE, WAIT_HI, WAIT_LO, SETUP, STROBE, HOLD, DONE.
- Reset values: SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB and SRAM_UB = 1. SRAM_A = BASE_ADDR. SRAM_DQ_OUT = 0 and SRAM_DQ_EN = 0. IN_READY, BUSY, DONE, OVERFLOW = 0. WORD_COUNT = 0. State = IDLE.
- IDLE or DONE + START: load SRAM_A with BASE_ADDR. Clear WORD_COUNT, DONE and OVERFLOW. Set BUSY=1 and go to WAIT_HI. START in any other state is ignored.
- Byte order is big-endian. The first accepted byte fills SRAM_DQ_OUT[15:8] and the state moves WAIT_HI→WAIT_LO. The second fills [7:0] and the state moves WAIT_LO→SETUP.
- A byte is accepted on an edge where IN_VALID && IN_READY. IN_READY = (state is WAIT_HI or WAIT_LO) and is a pure decode of the state register, with no path from IN_VALID.
- SETUP, 1 cycle: CE=0, LB=UB=0, DQ_EN=1, WE=1.
- STROBE, WE_CYCLES cycles: WE=0. CE, LB, UB and DQ_EN stay asserted. SRAM_A and SRAM_DQ_OUT are stable.
- HOLD, 1 cycle: WE=1, DQ_EN=1. On leaving HOLD:
  - WORD_COUNT increments and SRAM_A increments, wrapping 18'h3FFFF→0.
  - If DQ_OUT[15:12] = 0000, go to DONE.
  - Else, if the address just written was 18'h3FFFF, go to DONE and set OVERFLOW=1.
  - Otherwise go to WAIT_HI.
- In DONE: BUSY=0, DONE=1, CE=LB=UB=1, DQ_EN=0, IN_READY=0. Incoming bytes stay unconsumed.
- In WAIT_HI and WAIT_LO: CE=1, WE=1, DQ_EN=0.
- Reset asserted mid-operation forces all reset values immediately and asynchronously, including WE=1 during STROBE. The interrupted word is not counted and is not guaranteed to be written.

## Timing
- Low byte accepted at edge T: SETUP occupies T+1, STROBE occupies T+2 to T+1+WE_CYCLES, HOLD occupies T+2+WE_CYCLES.
- IN_READY rises one cycle after HOLD, at the earliest.
- Minimum period per word is 4+WE_CYCLES cycles: 2 byte cycles, SETUP, WE_CYCLES, and HOLD. With WE_CYCLES=2 this is 6 cycles.
- SRAM_A and SRAM_DQ_OUT never change while WE=0 or while DQ_EN=1.
- DONE and BUSY=0 become visible on the edge that exits HOLD.
- All outputs are registered except IN_READY, which is a state decode.

## Test plan
- Reset check: hold RST_N=0, toggle CLK. Required: every output equals its reset value, with WE=CE=OE=LB=UB=1 and SRAM_A=0.
- Basic load: WE_CYCLES=2, START, then bytes 10 60 82 03 00 00 with IN_VALID=1 throughout. Required:
  - writes 0x1060@0, 0x8203@1, 0x0000@2;
  - each write has WE=0 for exactly 2 cycles;
  - WORD_COUNT=3, DONE=1, BUSY=0, IN_READY=0;
  - 6 cycles per word.
- Backpressure and gaps: IN_VALID toggles every other cycle and a byte is presented during SETUP/STROBE/HOLD. Required:
  - IN_READY=0 in those states and the byte is not consumed;
  - the byte is taken on the first WAIT_HI edge;
  - written data is correct.
- Overflow: BASE_ADDR=18'h3FFFE, stream 81 00 81 01 81 02. Required:
  - writes at 3FFFE and 3FFFF only;
  - OVERFLOW=1, DONE=1, WORD_COUNT=2, SRAM_A=0;
  - the third word is never accepted.
- Reset mid-write: assert RST_N=0 while WE=0 in STROBE. Required: WE=1 and DQ_EN=0 immediately, with no clock edge; WORD_COUNT=0.
- Restart: START while BUSY has no effect. START in DONE clears DONE, OVERFLOW and WORD_COUNT, and the next word is written at BASE_ADDR.
